count_sched: RTL and testbench

- Run/pause/clear sequencer for the two-digit BCD counter datapath.
- Owns the tick prescaler, so the digit counter no longer runs from a divided clock. Everything runs on one clock; the block issues a one-cycle tick enable and updates the BCD digits on that tick.
- Counts up from 00 to a programmable limit, or down from the limit to 00. Stops at the terminal value and flags done.

---
 rtl/count_sched.sv | 144 ++++++++++++++
 tb/tb_count_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_sched.sv
// count_sched: run/pause/clear sequencer for a two-digit BCD counter.
//
// A single clock drives everything. An internal prescaler issues a one-cycle
// tick every DIV clocks while running. On each tick the BCD digits step up
// toward the limit {LIM_TENS,LIM_ONES}, or down toward 00. When a step lands
// on the terminal value, counting stops and done is raised.
//
// Ports
//   clkin    in   system clock, rising edge
//   clr      in   synchronous active-high reset, overrides all other inputs
//   start    in   pulse: begin counting (IDLE) or resume (PAUSE)
//   stop     in   pulse: pause counting (RUN)
//   clear    in   pulse: reload the start value for up_dn and go to IDLE
//   up_dn    in   direction, 1 = up, 0 = down; sampled on clear and IDLE+start
//   tick     out  one-cycle pulse in the cycle new digits first appear
//   ones     out  BCD ones digit
//   tens     out  BCD tens digit
//   running  out  state is RUN
//   done     out  state is DONE
module count_sched #(
  parameter int DIV      = 50,
  parameter int PW       = 6,
  parameter int LIM_TENS = 5,
  parameter int LIM_ONES = 9
) (
  input  logic       clkin,
  input  logic       clr,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up_dn,
  output logic       tick,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [7:0]    LIM_BCD    = {4'(LIM_TENS), 4'(LIM_ONES)};

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          dir, dir_nxt;
  logic [7:0]    digits, digits_nxt;   // {tens, ones}
  logic [7:0]    stepped;
  logic          tick_r, tick_nxt;

  // Terminal value for a direction: limit when counting up, 00 when down.
  function automatic logic is_term(input logic d, input logic [7:0] bcd);
    return d ? (bcd == LIM_BCD) : (bcd == 8'h00);
  endfunction

  // One BCD step in direction d, carrying/borrowing between the digits.
  function automatic logic [7:0] bcd_step(input logic d, input logic [7:0] bcd);
    logic [3:0] t, o;
    t = bcd[7:4];
    o = bcd[3:0];
    if (d) begin
      if (o == 4'd9) return {t + 4'd1, 4'd0};
      else           return {t, o + 4'd1};
    end else begin
      if (o == 4'd0) return {t - 4'd1, 4'd9};
      else           return {t, o - 4'd1};
    end
  endfunction

  // State register
  always_ff @(posedge clkin) begin
    if (clr) begin
      state  <= IDLE;
      presc  <= '0;
      dir    <= 1'b1;
      digits <= 8'h00;
      tick_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      dir    <= dir_nxt;
      digits <= digits_nxt;
      tick_r <= tick_nxt;
    end
  end

  // Next-state logic; clear outranks stop, which outranks start.
  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    dir_nxt    = dir;
    digits_nxt = digits;
    tick_nxt   = 1'b0;
    stepped    = bcd_step(dir, digits);

    if (clear) begin
      state_nxt  = IDLE;
      presc_nxt  = '0;
      dir_nxt    = up_dn;
      digits_nxt = up_dn ? 8'h00 : LIM_BCD;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stop && start) begin
            dir_nxt   = up_dn;
            presc_nxt = '0;
            // Already at the terminal value: finish without a tick.
            state_nxt = is_term(up_dn, digits) ? DONE : RUN;
          end
        end
        RUN: begin
          // stop beats a coincident wrap: the prescaler parks at DIV-1 so the
          // deferred step fires on the first RUN cycle after resume.
          if (stop) begin
            state_nxt = PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_nxt  = '0;
            tick_nxt   = 1'b1;
            digits_nxt = stepped;
            if (is_term(dir, stepped)) state_nxt = DONE;
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
        PAUSE: begin
          if (!stop && start) state_nxt = RUN;
        end
        DONE: begin
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs, all taken straight from registers
  always_comb begin
    tick    = tick_r;
    tens    = digits[7:4];
    ones    = digits[3:0];
    running = (state == RUN);
    done    = (state == DONE);
  end

endmodule

// File: tb/tb_count_sched.sv
module tb_count_sched;

  localparam int DIV = 4;

  logic       clkin = 1'b0;
  logic       clr = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0, up_dn = 1'b1;
  logic       tick, running, done;
  logic [3:0] ones, tens;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [3:0] t;
    logic [3:0] o;
    logic       d;
  } exp_t;

  exp_t q[$];

  count_sched #(.DIV(DIV), .PW(3), .LIM_TENS(1), .LIM_ONES(2)) dut (
    .clkin(clkin), .clr(clr), .start(start), .stop(stop), .clear(clear),
    .up_dn(up_dn), .tick(tick), .ones(ones), .tens(tens),
    .running(running), .done(done)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  // Expected tick: cycle number and the decimal value v shown with it.
  task automatic push(input int c, input int v, input bit d);
    exp_t e;
    e.c = c;
    e.t = 4'(v / 10);
    e.o = 4'(v % 10);
    e.d = d;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every tick must match the oldest expected entry.
  always @(negedge clkin) begin
    if (tick === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        assert (0) else begin
          errors++;
          $error("FAIL unexpected_tick: observed tick at cycle %0d digits=%h%h, required none", cyc, tens, ones);
        end
      end else begin
        exp_t e;
        e = q.pop_front();
        assert (cyc == e.c && tens === e.t && ones === e.o && done === e.d && running === !e.d) else begin
          errors++;
          $error("FAIL tick_value: observed cyc=%0d digits=%h%h done=%b run=%b, required cyc=%0d digits=%h%h done=%b run=%b",
                 cyc, tens, ones, done, running, e.c, e.t, e.o, e.d, !e.d);
        end
      end
    end
  end

  function automatic logic [10:0] ex(input bit tk, input bit rn, input bit dn, input int v);
    return {tk, rn, dn, 4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input logic [10:0] expv);
    logic [10:0] obs;
    obs = {tick, running, done, tens, ones};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed {tick,run,done,digits}=%b_%b_%b_%h, required %b_%b_%b_%h",
             tag, obs[10], obs[9], obs[8], obs[7:0], expv[10], expv[9], expv[8], expv[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  // Drive one cycle of pulses, sampled on the next rising edge.
  task automatic drive(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    step();
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s: observed %0d pending ticks after %0d cycles, required 0", tag, q.size(), budget);
    end
    q.delete();
  endtask

  initial begin
    int k, s;

    // Reset and idle
    step();
    clr = 1'b0;
    chk("reset", ex(0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_idle", ex(0, 0, 0, 0));
    end

    // Full up count to the limit
    up_dn = 1'b1;
    drive(0, 0, 1);
    chk("clear_up", ex(0, 0, 0, 0));
    k = cyc;
    for (int i = 1; i <= 12; i++) push(k + 1 + DIV * i, i, i == 12);
    drive(1, 0, 0);
    chk("start_up", ex(0, 1, 0, 0));
    drain("up_run", 70);
    chk("up_done", ex(0, 0, 1, 12));
    repeat (20) step();
    chk("up_done_hold", ex(0, 0, 1, 12));

    // Pause and resume preserving the prescaler fraction
    drive(0, 0, 1);
    k = cyc;
    for (int i = 1; i <= 3; i++) push(k + 1 + DIV * i, i, 0);
    drive(1, 0, 0);
    wait_until(k + 13 + 2);
    drive(0, 1, 0);
    chk("pause_enter", ex(0, 0, 0, 3));
    for (int i = 0; i < 10; i++) begin
      up_dn = i[0];
      step();
      chk("pause_hold", ex(0, 0, 0, 3));
    end
    up_dn = 1'b1;
    s = cyc;
    push(s + 3, 4, 0);
    drive(1, 0, 0);
    chk("resume", ex(0, 1, 0, 3));
    drain("resume_tick", 10);

    // Down count from the limit; up_dn changes mid-run are ignored
    up_dn = 1'b0;
    drive(0, 0, 1);
    chk("clear_down", ex(0, 0, 0, 12));
    k = cyc;
    for (int i = 1; i <= 12; i++) push(k + 1 + DIV * i, 12 - i, i == 12);
    drive(1, 0, 0);
    up_dn = 1'b1;
    drain("down_run", 70);
    chk("down_done", ex(0, 0, 1, 0));
    drive(1, 0, 0);
    repeat (8) step();
    chk("done_ignores_start", ex(0, 0, 1, 0));

    // start+stop+clear together, landing on a prescaler wrap
    up_dn = 1'b1;
    drive(0, 0, 1);
    k = cyc;
    push(k + 5, 1, 0);
    drive(1, 0, 0);
    wait_until(k + 8);
    chk("pre_clear", ex(0, 1, 0, 1));
    drive(1, 1, 1);
    chk("all_pulses", ex(0, 0, 0, 0));
    repeat (8) step();
    chk("all_pulses_idle", ex(0, 0, 0, 0));
    drain("all_pulses_q", 1);

    // stop on the wrap edge defers the step until after resume
    drive(0, 0, 1);
    k = cyc;
    push(k + 5, 1, 0);
    drive(1, 0, 0);
    wait_until(k + 8);
    drive(0, 1, 0);
    chk("stop_on_wrap", ex(0, 0, 0, 1));
    repeat (3) step();
    chk("stop_on_wrap_hold", ex(0, 0, 0, 1));
    s = cyc;
    push(s + 2, 2, 0);
    for (int i = 3; i <= 7; i++) push(s + 2 + DIV * (i - 2), i, 0);
    drive(1, 0, 0);
    drain("deferred_step", 40);
    chk("at_07", ex(0, 1, 0, 7));

    // clr together with start mid-run
    clr   = 1'b1;
    start = 1'b1;
    step();
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_mid_run", ex(0, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("clr_idle", ex(0, 0, 0, 0));
    end
    drain("final_q", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
